// File: rtl/seg_pkg.sv
// Shared types and code constants for the seven-segment display path.
// Codes 0x00-0x0F are hex digits, 0x10-0x19 letters, 0x1A-0x1F blank.
package seg_pkg;

   typedef logic [4:0] seg_code_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SCROLL = 1'b1
   } scroll_state_t;

   localparam seg_code_t CODE_BLANK = 5'h1F;
   localparam seg_code_t CODE_LTR_0 = 5'h10;
   localparam seg_code_t CODE_LTR_1 = 5'h11;
   localparam seg_code_t CODE_LTR_2 = 5'h12;
   localparam seg_code_t CODE_LTR_3 = 5'h13;
   localparam seg_code_t CODE_LTR_4 = 5'h14;
   localparam seg_code_t CODE_LTR_5 = 5'h15;
   localparam seg_code_t CODE_LTR_6 = 5'h16;
   localparam seg_code_t CODE_LTR_7 = 5'h17;
   localparam seg_code_t CODE_LTR_8 = 5'h18;
   localparam seg_code_t CODE_LTR_9 = 5'h19;

   function automatic logic is_blank(input seg_code_t c);
      return (c >= 5'h1A);
   endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Step-rate prescaler: counts 0..TICK_DIV-1, o_tick is high on the wrap cycle.
// Latency: tick every TICK_DIV cycles after i_clr drops; i_clr holds the count at 0.
module seg_tick_gen
   import seg_pkg::*;
#(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_cnt <= '0;
      end else if (i_clr || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/seg_scroller.sv
// Scrolls a buffered message of display codes right-to-left across DIGITS positions.
// Outputs are combinational from state; writes accepted only in IDLE. SEG_SCROLLER_LOOP_EN repeats passes.
module seg_scroller
   import seg_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int MSG_MAX  = 16,
   parameter int TICK_DIV = 1_000_000
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  wr_valid,
   input  logic [4:0]            wr_code,
   output logic                  wr_ready,
   input  logic                  clear,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [5*DIGITS-1:0]   digit_code,
   output logic [DIGITS-1:0]     digit_en
);

   localparam int LW = $clog2(MSG_MAX + 1);
   localparam int SW = $clog2(MSG_MAX + DIGITS);
   localparam int IW = SW + 1;
   localparam logic [LW-1:0] LEN_MAX = LW'(MSG_MAX);

   scroll_state_t r_state, w_state_nxt;
   logic [LW-1:0] r_len, w_len_nxt;
   logic [SW-1:0] r_s, w_s_nxt;
   logic          r_done, w_done_nxt;
   seg_code_t     r_buf [MSG_MAX];

   logic          w_tick;
   logic          w_wr_acc;
   logic [SW-1:0] w_s_end;
   logic signed [IW-1:0] w_len_s;

   seg_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .i_clk  (clk),
      .i_nrst (nrst),
      .i_clr  (r_state != ST_SCROLL),
      .o_tick (w_tick)
   );

   assign w_s_end = SW'(r_len) + SW'(DIGITS - 1);
   assign w_len_s = $signed(IW'(r_len));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_s     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_s     <= w_s_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_s_nxt     = r_s;
      w_done_nxt  = 1'b0;
      wr_ready    = 1'b0;
      w_wr_acc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            wr_ready = (r_len < LEN_MAX);
            // Clear wins over a same-cycle write, which is then dropped.
            w_wr_acc = wr_valid & wr_ready & ~clear;
            if (clear) begin
               w_len_nxt = '0;
            end else if (w_wr_acc) begin
               w_len_nxt = r_len + 1'b1;
            end
            if (start && !clear && ((r_len != '0) || w_wr_acc)) begin
               w_state_nxt = ST_SCROLL;
               w_s_nxt     = '0;
            end
         end
         ST_SCROLL: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
               w_s_nxt     = '0;
            end else if (w_tick) begin
               if (r_s == w_s_end) begin
                  w_s_nxt    = '0;
                  w_done_nxt = 1'b1;
`ifdef SEG_SCROLLER_LOOP_EN
                  w_state_nxt = ST_SCROLL;
`else
                  w_state_nxt = ST_IDLE;
`endif
               end else begin
                  w_s_nxt = r_s + 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Buffer has no reset: contents beyond len are never displayed.
   always_ff @(posedge clk) begin
      for (int j = 0; j < MSG_MAX; j++) begin
         if (w_wr_acc && (r_len == LW'(j))) begin
            r_buf[j] <= wr_code;
         end
      end
   end

   assign busy = (r_state == ST_SCROLL);
   assign done = r_done;

   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      logic signed [IW-1:0] w_idx;
      logic                 w_en;
      seg_code_t            w_code;

      assign w_idx = $signed({1'b0, r_s}) - $signed(IW'(d));

      always_comb begin
         w_en   = 1'b0;
         w_code = '0;
         if ((r_state == ST_SCROLL) && !w_idx[IW-1] && (w_idx < w_len_s)) begin
            w_en = 1'b1;
            for (int j = 0; j < MSG_MAX; j++) begin
               if (w_idx == $signed(IW'(j))) begin
                  w_code = r_buf[j];
               end
            end
         end
      end

      assign digit_en[d]          = w_en;
      assign digit_code[5*d +: 5] = w_code;
   end

endmodule

// File: tb/tb_seg_scroller.sv
// Directed bench for seg_scroller with DIGITS=4, MSG_MAX=16, TICK_DIV=4.
// Define SEG_SCROLLER_LOOP_EN for both bench and RTL to check the looping build.
module tb_seg_scroller;

   logic        clk = 1'b0;
   logic        nrst;
   logic        wr_valid;
   logic [4:0]  wr_code;
   logic        wr_ready;
   logic        clear;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [19:0] digit_code;
   logic [3:0]  digit_en;

   int n_cmp = 0;
   int n_err = 0;

   seg_scroller #(
      .DIGITS   (4),
      .MSG_MAX  (16),
      .TICK_DIV (4)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .wr_valid   (wr_valid),
      .wr_code    (wr_code),
      .wr_ready   (wr_ready),
      .clear      (clear),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .digit_code (digit_code),
      .digit_en   (digit_en)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] pk(input logic [4:0] c3, input logic [4:0] c2,
                                      input logic [4:0] c1, input logic [4:0] c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [4:0] c);
      wr_valid = 1'b1;
      wr_code  = c;
      step(1);
      wr_valid = 1'b0;
   endtask

   initial begin
      nrst = 1'b0; wr_valid = 1'b0; wr_code = '0;
      clear = 1'b0; start = 1'b0; abort = 1'b0;
      step(2);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_en", 32'(digit_en), 32'd0);
      chk("rst_code", 32'(digit_code), 32'd0);
      nrst = 1'b1;
      chk("rel_wr_ready", 32'(wr_ready), 32'd1);
      step(1);
      chk("rel_wr_ready2", 32'(wr_ready), 32'd1);

      // Five-code message, full pass
      wr(5'h11); wr(5'h0E); wr(5'h14); wr(5'h14); wr(5'h00);
      start = 1'b1;
      step(1); start = 1'b0;                       // t0+1
      chk("p_t1_busy", 32'(busy), 32'd1);
      chk("p_t1_en", 32'(digit_en), 32'b0001);
      chk("p_t1_code", 32'(digit_code), 32'(pk(5'h00, 5'h00, 5'h00, 5'h11)));
      step(4);                                     // t0+5
      chk("p_t5_en", 32'(digit_en), 32'b0011);
      chk("p_t5_code", 32'(digit_code), 32'(pk(5'h00, 5'h00, 5'h11, 5'h0E)));
      step(12);                                    // t0+17
      chk("p_t17_en", 32'(digit_en), 32'b1111);
      chk("p_t17_code", 32'(digit_code), 32'(pk(5'h0E, 5'h14, 5'h14, 5'h00)));
      step(12);                                    // t0+29, s=7
      chk("p_t29_en", 32'(digit_en), 32'b1000);
      chk("p_t29_code", 32'(digit_code), 32'd0);
      step(4);                                     // t0+33, s=8
      chk("p_t33_en", 32'(digit_en), 32'b0000);
      step(3);                                     // t0+36
      chk("p_t36_done", 32'(done), 32'd0);
      chk("p_t36_busy", 32'(busy), 32'd1);
      step(1);                                     // t0+37
      chk("p_t37_done", 32'(done), 32'd1);
`ifdef SEG_SCROLLER_LOOP_EN
      chk("loop_t37_busy", 32'(busy), 32'd1);
      chk("loop_t37_en", 32'(digit_en), 32'b0001);
      chk("loop_t37_code", 32'(digit_code), 32'(pk(5'h00, 5'h00, 5'h00, 5'h11)));
      step(1);
      chk("loop_t38_done", 32'(done), 32'd0);
      abort = 1'b1; step(1); abort = 1'b0;
      chk("loop_abort_busy", 32'(busy), 32'd0);
`else
      chk("p_t37_busy", 32'(busy), 32'd0);
      chk("p_t37_en", 32'(digit_en), 32'd0);
      step(1);
      chk("p_t38_done", 32'(done), 32'd0);
`endif

      // Abort at step 2, then replay
      start = 1'b1; step(1); start = 1'b0;
      step(8);                                     // s=2
      chk("ab_s2_en", 32'(digit_en), 32'b0111);
      chk("ab_s2_code", 32'(digit_code), 32'(pk(5'h00, 5'h11, 5'h0E, 5'h14)));
      abort = 1'b1; step(1); abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_en", 32'(digit_en), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      step(1);
      chk("ab_done2", 32'(done), 32'd0);
      start = 1'b1; step(1); start = 1'b0;
      chk("rp_t1_en", 32'(digit_en), 32'b0001);
      chk("rp_t1_code", 32'(digit_code), 32'(pk(5'h00, 5'h00, 5'h00, 5'h11)));
      step(4);
      chk("rp_t5_code", 32'(digit_code), 32'(pk(5'h00, 5'h00, 5'h11, 5'h0E)));
      abort = 1'b1; step(1); abort = 1'b0;

      // Clear, then start on an empty buffer is ignored
      clear = 1'b1; step(1); clear = 1'b0;
      start = 1'b1; step(1); start = 1'b0;
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_done", 32'(done), 32'd0);
      step(1);
      chk("empty_done2", 32'(done), 32'd0);

      // Clear drops a same-cycle write
      clear = 1'b1; wr_valid = 1'b1; wr_code = 5'h05;
      step(1);
      clear = 1'b0; wr_valid = 1'b0;
      start = 1'b1; step(1); start = 1'b0;
      chk("clrwr_busy", 32'(busy), 32'd0);

      // Start with a same-cycle write on an empty buffer; blank code stored as-is
      wr_valid = 1'b1; wr_code = 5'h1F; start = 1'b1;
      step(1);
      wr_valid = 1'b0; start = 1'b0;
      chk("sw_busy", 32'(busy), 32'd1);
      chk("sw_en", 32'(digit_en), 32'b0001);
      chk("sw_code", 32'(digit_code), 32'h1F);
      chk("sw_wr_ready", 32'(wr_ready), 32'd0);
      abort = 1'b1; step(1); abort = 1'b0;
      clear = 1'b1; step(1); clear = 1'b0;

      // Overfill: 17 writes, only 16 stored
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("fill_rdy_%0d", i), 32'(wr_ready), (i < 16) ? 32'd1 : 32'd0);
         wr(5'(i));
      end
      chk("fill_rdy_end", 32'(wr_ready), 32'd0);
      start = 1'b1; step(1); start = 1'b0;
      step(64);                                    // s=16
      chk("fill_s16_en", 32'(digit_en), 32'b1110);
      chk("fill_s16_code", 32'(digit_code), 32'(pk(5'h0D, 5'h0E, 5'h0F, 5'h00)));

      // Asynchronous reset mid-scroll
      #2 nrst = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_en", 32'(digit_en), 32'd0);
      chk("ar_code", 32'(digit_code), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      step(1);
      nrst = 1'b1;
      start = 1'b1; step(1); start = 1'b0;
      chk("ar_len0_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
